// File: rtl/line_capture.sv
// Line capture: stores one sensor line of ADC samples on synchronized TRIG edges,
// then streams the line out through a valid/ready port with a last-pixel marker.
module line_capture #(
  parameter int PIX_MAX = 1024,
  parameter int DATA_W  = 12
) (
  input  logic              FPGA_CLK,
  input  logic              FPGA_RST,
  input  logic              ST,
  input  logic              TRIG,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              EOC_EDGE,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic [10:0]       PIX_COUNT,
  output logic              OVERFLOW,
  output logic              MISSED,
  output logic              BUSY
);

  // state   | meaning
  // IDLE    | waiting for an ST rising edge to arm a line
  // CAPTURE | storing one sample per synchronized TRIG edge until EOC_EDGE
  // DRAIN   | streaming pixels 0..PIX_COUNT-1 to the consumer

  localparam int          AW        = (PIX_MAX > 1) ? $clog2(PIX_MAX) : 1;
  localparam logic [10:0] PIX_MAX_C = 11'(PIX_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              st_q;
  logic              trig_s1_q, trig_s2_q, trig_s3_q;
  logic [10:0]       pix_cnt_q, pix_cnt_d;
  logic [10:0]       rd_idx_q, rd_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic              missed_q, missed_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] buf_mem [PIX_MAX];

  logic st_edge, trig_edge, wr_en, rd_en, xfer, at_last;

  assign st_edge   = ST & ~st_q;
  assign trig_edge = trig_s2_q & ~trig_s3_q;
  assign wr_en     = (state_q == CAPTURE) && trig_edge && (pix_cnt_q < PIX_MAX_C);
  assign rd_en     = (state_q == DRAIN);
  assign xfer      = out_valid_q & OUT_READY;
  assign at_last   = (rd_idx_q == (pix_cnt_q - 11'd1));

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      state_q     <= IDLE;
      st_q        <= 1'b0;
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_s3_q   <= 1'b0;
      pix_cnt_q   <= 11'd0;
      rd_idx_q    <= 11'd0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= ST;
      trig_s1_q   <= TRIG;
      trig_s2_q   <= trig_s1_q;
      trig_s3_q   <= trig_s2_q;
      pix_cnt_q   <= pix_cnt_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      missed_q    <= missed_d;
    end
  end

  // EOC decision uses the post-write count so a coincident last pixel is kept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (st_edge) state_d = CAPTURE;
      CAPTURE: if (EOC_EDGE) state_d = (pix_cnt_d != 11'd0) ? DRAIN : IDLE;
      DRAIN:   if (xfer && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    rd_idx_d    = 11'd0;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    missed_d    = missed_q;
    case (state_q)
      IDLE: begin
        if (st_edge) pix_cnt_d = 11'd0;
      end
      CAPTURE: begin
        if (wr_en)          pix_cnt_d  = pix_cnt_q + 11'd1;
        else if (trig_edge) overflow_d = 1'b1;
      end
      DRAIN: begin
        missed_d    = missed_q | st_edge;
        rd_idx_d    = xfer ? (rd_idx_q + 11'd1) : rd_idx_q;
        out_valid_d = !(xfer && at_last);
      end
      default: ;
    endcase
  end

  always_comb begin
    BUSY      = (state_q != IDLE);
    OUT_VALID = out_valid_q;
    OUT_LAST  = out_valid_q & at_last;
    OUT_DATA  = rd_data_q;
    PIX_COUNT = pix_cnt_q;
    OVERFLOW  = overflow_q;
    MISSED    = missed_q;
  end

  always_ff @(posedge FPGA_CLK) begin
    if (wr_en) buf_mem[pix_cnt_q[AW-1:0]] <= ADC_DATA;
  end

  // Read address runs one index ahead on a transfer, so the output register
  // always holds buffer[rd_idx_q] and stays put while the consumer stalls.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST)  rd_data_q <= '0;
    else if (rd_en) rd_data_q <= buf_mem[rd_idx_d[AW-1:0]];
  end

endmodule

// File: tb/tb_line_capture.sv
// Bench for line_capture: a default-size instance and a PIX_MAX=4 instance share
// all stimulus; each has its own expected-pixel queue and stream monitor.
module tb_line_capture;

  localparam int DW        = 12;
  localparam int BIG_MAX   = 1024;
  localparam int SMALL_MAX = 4;

  logic          clk = 1'b0;
  logic          rst_b, st, trig, eoc, rdy;
  logic [DW-1:0] adc;

  logic [DW-1:0] b_data, s_data;
  logic          b_valid, s_valid, b_last, s_last;
  logic          b_ovf, s_ovf, b_miss, s_miss, b_busy, s_busy;
  logic [10:0]   b_cnt, s_cnt;

  always #5 clk = ~clk;

  line_capture #(.PIX_MAX(BIG_MAX), .DATA_W(DW)) dut (
    .FPGA_CLK(clk), .FPGA_RST(rst_b), .ST(st), .TRIG(trig), .ADC_DATA(adc),
    .EOC_EDGE(eoc), .OUT_DATA(b_data), .OUT_VALID(b_valid), .OUT_READY(rdy),
    .OUT_LAST(b_last), .PIX_COUNT(b_cnt), .OVERFLOW(b_ovf), .MISSED(b_miss),
    .BUSY(b_busy)
  );

  line_capture #(.PIX_MAX(SMALL_MAX), .DATA_W(DW)) dut_small (
    .FPGA_CLK(clk), .FPGA_RST(rst_b), .ST(st), .TRIG(trig), .ADC_DATA(adc),
    .EOC_EDGE(eoc), .OUT_DATA(s_data), .OUT_VALID(s_valid), .OUT_READY(rdy),
    .OUT_LAST(s_last), .PIX_COUNT(s_cnt), .OVERFLOW(s_ovf), .MISSED(s_miss),
    .BUSY(s_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard model
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] q_s[$];
  int            exp_cnt_b = 0;
  int            exp_cnt_s = 0;
  logic          exp_ovf_s = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // big-instance monitor
  logic          b_stall = 1'b0, b_hold_last = 1'b0, b_seen = 1'b0;
  logic [DW-1:0] b_hold = '0;
  int            b_xfers = 0, b_first = 0, b_lastc = 0, b_stall_n = 0;

  always @(negedge clk) begin
    if (b_stall && rst_b) begin
      check("b_stall_valid", b_valid, 1);
      check("b_stall_data", b_data, b_hold);
      check("b_stall_last", b_last, b_hold_last);
      b_stall_n++;
    end
    if (b_valid) b_seen = 1'b1;
    if (b_valid && rdy) begin
      check("b_xfer_expected", q_b.size() > 0, 1);
      if (q_b.size() > 0) begin
        check("b_data", b_data, q_b[0]);
        check("b_last", b_last, q_b.size() == 1);
        void'(q_b.pop_front());
      end
      b_xfers++;
      if (b_xfers == 1) b_first = cyc;
      b_lastc = cyc;
    end
    b_stall     = b_valid && !rdy && rst_b;
    b_hold      = b_data;
    b_hold_last = b_last;
  end

  // small-instance monitor
  logic          s_stall = 1'b0, s_hold_last = 1'b0, s_seen = 1'b0;
  logic [DW-1:0] s_hold = '0;
  int            s_xfers = 0;

  always @(negedge clk) begin
    if (s_stall && rst_b) begin
      check("s_stall_valid", s_valid, 1);
      check("s_stall_data", s_data, s_hold);
      check("s_stall_last", s_last, s_hold_last);
    end
    if (s_valid) s_seen = 1'b1;
    if (s_valid && rdy) begin
      check("s_xfer_expected", q_s.size() > 0, 1);
      if (q_s.size() > 0) begin
        check("s_data", s_data, q_s[0]);
        check("s_last", s_last, q_s.size() == 1);
        void'(q_s.pop_front());
      end
      s_xfers++;
    end
    s_stall     = s_valid && !rdy && rst_b;
    s_hold      = s_data;
    s_hold_last = s_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line();
    exp_cnt_b = 0;
    exp_cnt_s = 0;
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
  endtask

  task automatic push_pixel(input logic [DW-1:0] d);
    if (exp_cnt_b < BIG_MAX) begin q_b.push_back(d); exp_cnt_b++; end
    if (exp_cnt_s < SMALL_MAX) begin q_s.push_back(d); exp_cnt_s++; end
    else exp_ovf_s = 1'b1;
  endtask

  task automatic pixel(input logic [DW-1:0] d);
    push_pixel(d);
    adc  = d;
    trig = 1'b1;
    repeat (2) tick();
    trig = 1'b0;
    repeat (2) tick();
    adc = DW'($urandom);
    repeat (2) tick();
  endtask

  task automatic eoc_pulse();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!b_busy && !s_busy) break;
      tick();
    end
    check("idle_timeout", {b_busy, s_busy}, 0);
  endtask

  task automatic end_line(input string tag);
    wait_idle();
    tick();
    check({tag, "_b_queue_left"}, q_b.size(), 0);
    check({tag, "_s_queue_left"}, q_s.size(), 0);
    check({tag, "_b_pix_count"}, b_cnt, exp_cnt_b);
    check({tag, "_s_pix_count"}, s_cnt, exp_cnt_s);
    check({tag, "_b_overflow"}, b_ovf, 0);
    check({tag, "_s_overflow"}, s_ovf, exp_ovf_s);
    check({tag, "_valid_idle"}, {b_valid, s_valid}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_b_valid"}, b_valid, 0);
    check({tag, "_b_last"}, b_last, 0);
    check({tag, "_b_data"}, b_data, 0);
    check({tag, "_b_cnt"}, b_cnt, 0);
    check({tag, "_b_ovf"}, b_ovf, 0);
    check({tag, "_b_miss"}, b_miss, 0);
    check({tag, "_b_busy"}, b_busy, 0);
    check({tag, "_s_valid"}, s_valid, 0);
    check({tag, "_s_data"}, s_data, 0);
    check({tag, "_s_cnt"}, s_cnt, 0);
    check({tag, "_s_ovf"}, s_ovf, 0);
    check({tag, "_s_miss"}, s_miss, 0);
    check({tag, "_s_busy"}, s_busy, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    st    = 1'b0;
    trig  = 1'b0;
    eoc   = 1'b0;
    rdy   = 1'b1;
    adc   = '0;
    repeat (3) tick();
    check_reset_outputs("por");
    rst_b = 1'b1;
    repeat (2) tick();

    // coincident: third TRIG edge detected in the same cycle as EOC_EDGE
    start_line();
    pixel(12'h101);
    pixel(12'h102);
    push_pixel(12'h103);
    adc  = 12'h103;
    trig = 1'b1;
    repeat (2) tick();
    eoc = 1'b1;
    tick();
    eoc  = 1'b0;
    trig = 1'b0;
    tick();
    adc = DW'($urandom);
    end_line("coinc");
    check("coinc_b_cnt3", b_cnt, 3);

    // empty line
    b_seen = 1'b0;
    s_seen = 1'b0;
    start_line();
    eoc_pulse();
    end_line("empty");
    check("empty_b_no_valid", b_seen, 0);
    check("empty_s_no_valid", s_seen, 0);

    // overflow on the PIX_MAX=4 instance
    start_line();
    for (int i = 1; i <= 4; i++) pixel(DW'(12'h210 + i));
    check("ovf_clear_at_max", s_ovf, 0);
    pixel(12'h215);
    check("ovf_set_past_max", s_ovf, 1);
    check("ovf_cnt_held", s_cnt, 4);
    pixel(12'h216);
    eoc_pulse();
    end_line("ovf");
    check("ovf_big_cnt6", b_cnt, 6);

    // basic line, with an ST pulse mid-capture that must be ignored
    b_xfers = 0;
    start_line();
    pixel(12'h001);
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) pixel(DW'(i));
    eoc_pulse();
    end_line("basic");
    check("basic_xfers", b_xfers, 5);
    check("basic_back_to_back", b_lastc - b_first, 4);
    check("basic_no_missed", b_miss, 0);

    // backpressure with OUT_READY pattern 1,0,0,1
    b_xfers   = 0;
    b_stall_n = 0;
    start_line();
    for (int i = 1; i <= 5; i++) pixel(DW'(12'h300 + i));
    rdy = 1'b0;
    eoc_pulse();
    for (int i = 0; i < 80; i++) begin
      if (!b_busy && !s_busy) break;
      rdy = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    rdy = 1'b1;
    end_line("bp");
    check("bp_xfers", b_xfers, 5);
    check("bp_stalls_seen", b_stall_n > 0, 1);

    // ST during DRAIN, then reset mid-DRAIN
    start_line();
    for (int i = 1; i <= 5; i++) pixel(DW'(12'h400 + i));
    rdy = 1'b0;
    eoc_pulse();
    repeat (4) tick();
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    check("missed_b", b_miss, 1);
    check("missed_s", s_miss, 1);
    check("drain_busy", b_busy, 1);
    check("drain_valid", b_valid, 1);
    rst_b = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q_b.delete();
    q_s.delete();
    exp_cnt_b = 0;
    exp_cnt_s = 0;
    exp_ovf_s = 1'b0;
    tick();
    rst_b  = 1'b1;
    rdy    = 1'b1;
    b_seen = 1'b0;
    s_seen = 1'b0;
    repeat (20) tick();
    check("postrst_b_no_valid", b_seen, 0);
    check("postrst_s_no_valid", s_seen, 0);
    check("postrst_busy", {b_busy, s_busy}, 0);

    // recovery line after reset
    start_line();
    pixel(12'h0AB);
    pixel(12'h0CD);
    eoc_pulse();
    end_line("recover");
    check("recover_missed", b_miss, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_capture.md
LINE_CAPTURE -- requirements
Module: line_capture

Interface
REQ-001 SHALL have parameter PIX_MAX, default 1024, the maximum pixels stored per line.
REQ-002 SHALL have parameter DATA_W, default 12, the ADC sample width in bits.
REQ-003 SHALL have port FPGA_CLK  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port FPGA_RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ST  input  1  sensor start pulse, synchronous to FPGA_CLK; a rising edge arms a line.
REQ-006 SHALL have port TRIG  input  1  sensor pixel trigger, asynchronous to FPGA_CLK.
REQ-007 SHALL have port ADC_DATA  input  DATA_W  pixel sample, stable for at least 4 FPGA_CLK cycles after the TRIG rising edge.
REQ-008 SHALL have port EOC_EDGE  input  1  one-cycle end-of-conversion pulse, synchronous to FPGA_CLK.
REQ-009 SHALL have port OUT_DATA  output  DATA_W  stream pixel data.
REQ-010 SHALL have port OUT_VALID  output  1  stream valid.
REQ-011 SHALL have port OUT_READY  input  1  stream ready from the consumer.
REQ-012 SHALL have port OUT_LAST  output  1  marks the final pixel of a line.
REQ-013 SHALL have port PIX_COUNT  output  11  pixels captured in the current or last line.
REQ-014 SHALL have port OVERFLOW  output  1  sticky flag for a pixel dropped past PIX_MAX.
REQ-015 SHALL have port MISSED  output  1  sticky flag for an ST edge ignored during DRAIN.
REQ-016 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement an FSM with states IDLE, CAPTURE and DRAIN.
REQ-018 SHALL synchronize TRIG through 2 flip-flops, then rising-edge detect it against a third registered copy.
REQ-019 SHALL, in IDLE, go to CAPTURE on a rising edge of ST, clearing the write address and PIX_COUNT to 0 on the same edge.
REQ-020 SHALL, in CAPTURE, write ADC_DATA to buffer[wr_addr] and increment wr_addr and PIX_COUNT on each detected TRIG edge; the write occurs on the 3rd FPGA_CLK rising edge after TRIG goes high.
REQ-021 SHALL, in CAPTURE with PIX_COUNT == PIX_MAX, not write a TRIG edge, hold PIX_COUNT, and set OVERFLOW to 1.
REQ-022 SHALL, in CAPTURE on EOC_EDGE, go to DRAIN if PIX_COUNT > 0, else return to IDLE.
REQ-023 SHALL, when a TRIG edge and EOC_EDGE coincide in CAPTURE, write the pixel first, then act on EOC with the incremented count.
REQ-024 SHALL use a synchronous-read buffer memory of PIX_MAX x DATA_W with a 1-cycle read latency.
REQ-025 SHALL, in DRAIN, present pixels 0..PIX_COUNT-1 in order on OUT_DATA with OUT_VALID.
REQ-026 SHALL assert OUT_VALID no later than 2 cycles after entering DRAIN.
REQ-027 SHALL transfer a pixel on a cycle with OUT_VALID=1 and OUT_READY=1.
REQ-028 SHALL hold OUT_DATA, OUT_VALID and OUT_LAST stable while OUT_VALID=1 and OUT_READY=0.
REQ-029 SHALL sustain one transfer per cycle while OUT_READY is held at 1.
REQ-030 SHALL drive OUT_LAST=1 only with pixel index PIX_COUNT-1.
REQ-031 SHALL return to IDLE on the cycle after the OUT_LAST transfer; OUT_VALID SHALL be 0 in IDLE and CAPTURE.
REQ-032 SHALL ignore ST edges in CAPTURE.
REQ-033 SHALL ignore ST edges in DRAIN and set MISSED to 1 for each such edge.
REQ-034 SHALL ignore TRIG and EOC_EDGE outside CAPTURE.
REQ-035 SHALL hold PIX_COUNT after a line until the next ST edge accepted in IDLE.
REQ-036 SHALL clear OVERFLOW and MISSED only by reset.

Reset
REQ-037 SHALL, with FPGA_RST=0, immediately force state IDLE, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, PIX_COUNT=0, OVERFLOW=0, MISSED=0, BUSY=0, and clear the synchronizer flops and addresses; buffer contents need not be cleared.
REQ-038 SHALL, on reset asserted mid-CAPTURE or mid-DRAIN, abandon the line with no further output after release until a new ST edge.

Verification
REQ-039 SHALL verify a basic line: ST edge, 5 TRIG pulses with ADC_DATA=0x001..0x005, EOC_EDGE, OUT_READY=1 -> 5 transfers 0x001..0x005 on consecutive cycles, OUT_LAST only on 0x005, PIX_COUNT=5, then IDLE.
REQ-040 SHALL verify backpressure: same line with OUT_READY toggled 1,0,0,1... -> data order unchanged, OUT_DATA stable while stalled, exactly 5 transfers.
REQ-041 SHALL verify overflow: PIX_MAX=4, 6 TRIG pulses -> PIX_COUNT=4, OVERFLOW=1, only the first 4 samples streamed.
REQ-042 SHALL verify an empty line: ST edge then EOC_EDGE with no TRIG -> returns to IDLE, OUT_VALID never asserted, PIX_COUNT=0.
REQ-043 SHALL verify a coincident edge: TRIG edge detected on the same cycle as EOC_EDGE as the 3rd pixel -> 3 pixels streamed.
REQ-044 SHALL verify reset mid-operation: ST edge during DRAIN -> MISSED=1; then FPGA_RST low for 1 cycle mid-DRAIN -> all outputs at reset values and no OUT_VALID until a new line.
